lcd_char_writer: RTL and testbench
==================================

# lcd_char_writer

Downstream consumer of the keypad decode stage: takes the ASCII character byte that stage produces, plus a one-cycle write strobe, and drives a 16x2 HD44780-compatible character LCD over an 8-bit, write-only bus. On its own it:
- runs the power-up initialisation sequence;
- tracks the cursor across both lines, wrapping at the end of the display;
- buffers one character written while the bus is busy;
- services a clear-display request.

## Interface
- T_PWRUP, 750000, power-up wait in clk cycles (15 ms at 50 MHz)
- T_EN, 25, lcd_e high time in cycles
- T_CMD, 2500, post-pulse wait for ordinary commands and data writes
- T_CLR, 82000, post-pulse wait for the clear command (0x01)
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- i_char  input  8  ASCII character to display
- i_wr  input  1  one-cycle strobe; i_char sampled on this cycle
- i_clr  input  1  one-cycle strobe; clear display and home cursor
- lcd_e  output  1  LCD enable
- lcd_rs  output  1  0 = command, 1 = data
- lcd_rw  output  1  constant 0 (write only)
- lcd_data  output  8  LCD data bus
- o_busy  output  1  high unless idle with nothing pending
- o_ovf  output  1  one-cycle pulse when a write is dropped

## Operation
- All timing counters are 20 bits wide; every parameter must be < 2^20.
- States:
  - PWR: count T_PWRUP cycles.
  - SETUP (1 cycle): drive lcd_rs and lcd_data, lcd_e = 0.
  - PULSE (T_EN cycles): lcd_e = 1.
  - HOLD: lcd_e = 0, wait T_CMD cycles, or T_CLR cycles if the byte sent was 0x01.
  - IDLE.
- Init sequence: after PWR, send the commands 0x38, 0x0C, 0x06, 0x01 in that order, each as one SETUP/PULSE/HOLD transaction. Then enter IDLE with pos = 0.
- Cursor position pos is 0..31; 0-15 is line 1 and 16-31 is line 2.
- Character write (lcd_rs = 1, lcd_data = char), then pos increments.
  - When the character goes to pos 16, the write is first preceded by command 0xC0.
  - After pos 31, pos wraps to 0, and the next write is preceded by command 0x80.
- Clear: send command 0x01 with a T_CLR wait, then pos = 0 and the wrap-address flag is cleared.
- Accepting requests:
  - In IDLE, i_wr or i_clr starts a transaction on the next cycle.
  - While busy, i_wr loads a 1-deep pending character buffer and i_clr sets a pending-clear flag.
- Priority:
  - i_clr wins over i_wr in the same cycle; that i_wr is discarded without an o_ovf pulse.
  - A pending clear discards any pending character.
  - Pending work is started from HOLD completion in preference to returning to IDLE.
- Overflow: i_wr while busy with the char buffer already full drops the new char, keeps the old one and pulses o_ovf for 1 cycle. i_wr while busy with a clear already pending is dropped the same way.
- i_wr or i_clr during PWR or init is handled like any busy-period request: buffered, or dropped with o_ovf under the overflow rule.

## Timing
- Reset values: lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 0x00, o_busy = 1, o_ovf = 0.
- Internal state at reset: state PWR, pos = 0, buffers empty.
- Reset mid-operation immediately forces the reset values above and restarts PWR; an in-flight lcd_e pulse is truncated.
- Data write with no address prefix, i_wr at cycle n in IDLE:
  - SETUP at n+1;
  - lcd_e high for cycles n+2 .. n+1+T_EN;
  - HOLD for T_CMD cycles;
  - IDLE again at n+2+T_EN+T_CMD, with o_busy low that cycle if nothing is pending.
- With an address prefix, two back-to-back transactions run with no IDLE cycle between them.
- lcd_data and lcd_rs are stable from SETUP through the end of PULSE and hold their value during HOLD.
- o_busy is registered and goes high on cycle n+1.

## Test plan
- Power-up, with T_PWRUP=10, T_EN=2, T_CMD=4, T_CLR=8: lcd_e pulses carry 0x38, 0x0C, 0x06, 0x01 in order, with rs = 0. The first pulse starts at cycle 11 after reset release. o_busy falls only after the 0x01 HOLD of 8 cycles.
- Single write of 0x35 in IDLE: exactly one lcd_e pulse, 2 cycles wide, with rs = 1 and data 0x35. o_busy is high for 1+2+4 cycles.
- 17 writes of 0x31: pulse 17 is preceded by a 0xC0 command pulse (rs = 0). A further 16 writes take pos to 31 and wrap it to 0; the 33rd write is preceded by 0x80.
- Busy buffering: with 0x32 in progress, i_wr 0x33 then i_wr 0x34 → 0x32 then 0x33 are written, 0x34 is never written, and o_ovf pulses once on the 0x34 cycle.
- Clear priority: i_clr and i_wr 0x39 in the same IDLE cycle → only 0x01 is sent, with an 8-cycle HOLD. The next write lands at pos 0 with no 0x80 prefix.
- Reset asserted mid-PULSE: lcd_e drops asynchronously, and the full init sequence repeats after the T_PWRUP wait.

Source files
------------

// File: rtl/lcd_char_writer.sv
// HD44780 character writer: power-up init, cursor tracking with line/wrap addressing,
// one-deep character buffer and a clear-display request, over an 8-bit write-only bus.
module lcd_char_writer #(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_CMD   = 2500,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_char,
    input  logic       i_wr,
    input  logic       i_clr,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       o_busy,
    output logic       o_ovf
);

    localparam int unsigned CW = 20;
    localparam logic [CW-1:0] PWR_LAST = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(T_EN - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(T_CLR - 1);

    typedef enum logic [2:0] {PWR, SETUP, PULSE, HOLD, IDLE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    init_idx_q;
    logic          in_init_q;
    logic [4:0]    pos_q;
    logic          wrap_q;
    logic          char_after_q;
    logic [7:0]    cur_char_q;
    logic [7:0]    pchar_q;
    logic          pchar_v_q;
    logic          pclr_q;
    logic          lcd_e_q;
    logic          lcd_rs_q;
    logic [7:0]    lcd_data_q;
    logic          busy_q;
    logic          ovf_q;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    logic [CW-1:0] hold_last_c;
    logic          hold_done_c;
    logic          init_more_c;
    logic          hold_final_c;
    logic          pend_any_c;
    logic          start_pt_c;
    logic          take_p_c;

    // A transaction ends with no follow-on (init step or prefixed char) at hold_final
    assign hold_last_c  = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLR_LAST : CMD_LAST;
    assign hold_done_c  = (state_q == HOLD) && (cnt_q == hold_last_c);
    assign init_more_c  = in_init_q && (init_idx_q != 2'd3);
    assign hold_final_c = hold_done_c && !init_more_c && !char_after_q;
    assign pend_any_c   = pclr_q | pchar_v_q;
    assign start_pt_c   = hold_final_c || (state_q == IDLE);
    assign take_p_c     = start_pt_c && pend_any_c;

    // Cursor state as it stands once the finishing transaction is accounted for
    logic [4:0] sel_pos_c;
    logic       sel_wrap_c;
    always_comb begin
        sel_pos_c  = pos_q;
        sel_wrap_c = wrap_q;
        if (hold_final_c) begin
            if (in_init_q || !lcd_rs_q) begin
                sel_pos_c  = 5'd0;
                sel_wrap_c = 1'b0;
            end else if (pos_q == 5'd31) begin
                sel_pos_c  = 5'd0;
                sel_wrap_c = 1'b1;
            end else begin
                sel_pos_c = pos_q + 5'd1;
            end
        end
    end

    // Choose the next job and the first byte it puts on the bus
    logic       req_clr_c;
    logic       req_wr_c;
    logic [7:0] req_char_c;
    logic       go_c;
    logic       launch_rs_c;
    logic [7:0] launch_data_c;
    logic       launch_pre_c;
    logic       wrap_keep_c;
    always_comb begin
        req_clr_c  = 1'b0;
        req_wr_c   = 1'b0;
        req_char_c = i_char;
        if (take_p_c) begin
            req_clr_c  = pclr_q;
            req_wr_c   = pchar_v_q && !pclr_q;
            req_char_c = pchar_q;
        end else if (state_q == IDLE) begin
            req_clr_c = i_clr;
            req_wr_c  = i_wr && !i_clr;
        end
        go_c          = req_clr_c | req_wr_c;
        launch_rs_c   = 1'b0;
        launch_data_c = 8'h01;
        launch_pre_c  = 1'b0;
        wrap_keep_c   = sel_wrap_c;
        if (!req_clr_c && req_wr_c) begin
            if (sel_wrap_c) begin
                launch_data_c = 8'h80;
                launch_pre_c  = 1'b1;
                wrap_keep_c   = 1'b0;
            end else if (sel_pos_c == 5'd16) begin
                launch_data_c = 8'hC0;
                launch_pre_c  = 1'b1;
            end else begin
                launch_rs_c   = 1'b1;
                launch_data_c = req_char_c;
            end
        end
    end

    // Pending buffers: freed by the job taken this cycle, then refilled by new strobes
    logic       pclr_d;
    logic       pchar_v_d;
    logic [7:0] pchar_d;
    logic       ovf_d;
    logic       busy_d;
    always_comb begin
        pclr_d    = take_p_c ? 1'b0 : pclr_q;
        pchar_v_d = take_p_c ? 1'b0 : pchar_v_q;
        pchar_d   = pchar_q;
        ovf_d     = 1'b0;
        if ((state_q != IDLE) || pend_any_c) begin
            if (i_clr) begin
                pclr_d    = 1'b1;
                pchar_v_d = 1'b0;
            end else if (i_wr) begin
                if (pclr_d || pchar_v_d) begin
                    ovf_d = 1'b1;
                end else begin
                    pchar_v_d = 1'b1;
                    pchar_d   = i_char;
                end
            end
        end
        busy_d = !(start_pt_c && !go_c) || pclr_d || pchar_v_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PWR;
            cnt_q        <= '0;
            init_idx_q   <= 2'd0;
            in_init_q    <= 1'b0;
            pos_q        <= 5'd0;
            wrap_q       <= 1'b0;
            char_after_q <= 1'b0;
            cur_char_q   <= 8'h00;
            pchar_q      <= 8'h00;
            pchar_v_q    <= 1'b0;
            pclr_q       <= 1'b0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            busy_q       <= 1'b1;
            ovf_q        <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            pclr_q    <= pclr_d;
            pchar_v_q <= pchar_v_d;
            pchar_q   <= pchar_d;
            if (start_pt_c) begin
                pos_q     <= sel_pos_c;
                wrap_q    <= wrap_keep_c;
                in_init_q <= 1'b0;
                cnt_q     <= '0;
                if (go_c) begin
                    state_q      <= SETUP;
                    lcd_rs_q     <= launch_rs_c;
                    lcd_data_q   <= launch_data_c;
                    char_after_q <= launch_pre_c;
                    cur_char_q   <= req_char_c;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    PWR: begin
                        if (cnt_q == PWR_LAST) begin
                            cnt_q      <= '0;
                            state_q    <= SETUP;
                            in_init_q  <= 1'b1;
                            init_idx_q <= 2'd0;
                            lcd_rs_q   <= 1'b0;
                            lcd_data_q <= init_cmd(2'd0);
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    SETUP: begin
                        state_q <= PULSE;
                        lcd_e_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                    PULSE: begin
                        if (cnt_q == EN_LAST) begin
                            lcd_e_q <= 1'b0;
                            state_q <= HOLD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    HOLD: begin
                        if (hold_done_c) begin
                            cnt_q   <= '0;
                            state_q <= SETUP;
                            if (init_more_c) begin
                                init_idx_q <= init_idx_q + 2'd1;
                                lcd_data_q <= init_cmd(init_idx_q + 2'd1);
                            end else begin
                                char_after_q <= 1'b0;
                                lcd_rs_q     <= 1'b1;
                                lcd_data_q   <= cur_char_q;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= PWR;
                endcase
            end
        end
    end

    assign lcd_e    = lcd_e_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = lcd_data_q;
    assign o_busy   = busy_q;
    assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Self-checking bench for lcd_char_writer: a cursor/command model predicts every bus
// transaction, a monitor checks each lcd_e pulse, and directed tests pin timing literally.
module tb_lcd_char_writer;

    localparam int unsigned T_PWRUP = 10;
    localparam int unsigned T_EN    = 2;
    localparam int unsigned T_CMD   = 4;
    localparam int unsigned T_CLR   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_char;
    logic       i_wr;
    logic       i_clr;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       o_busy;
    logic       o_ovf;

    lcd_char_writer #(
        .T_PWRUP(T_PWRUP), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .clk(clk), .rst(rst), .i_char(i_char), .i_wr(i_wr), .i_clr(i_clr),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
        .o_busy(o_busy), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: expected bus transactions as {rs, data}
    logic [8:0] expq[$];
    int         m_pos  = 0;
    bit         m_wrap = 0;

    task automatic model_init();
        expq.push_back(9'h038);
        expq.push_back(9'h00C);
        expq.push_back(9'h006);
        expq.push_back(9'h001);
        m_pos  = 0;
        m_wrap = 0;
    endtask

    task automatic model_write(input logic [7:0] c);
        if (m_wrap) begin
            expq.push_back(9'h080);
            m_wrap = 0;
        end else if (m_pos == 16) begin
            expq.push_back(9'h0C0);
        end
        expq.push_back({1'b1, c});
        m_pos++;
        if (m_pos == 32) begin
            m_pos  = 0;
            m_wrap = 1;
        end
    endtask

    task automatic model_clear();
        expq.push_back(9'h001);
        m_pos  = 0;
        m_wrap = 0;
    endtask

    int edge_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Bus monitor: every lcd_e pulse is compared with the model's next transaction
    int         pulses  = 0;
    int         ovf_cnt = 0;
    int         width   = 0;
    int         last_rise = 0;
    bit         in_pulse = 0;
    logic [8:0] p_tx, last_tx, prev_tx;
    always @(negedge clk) begin
        if (o_ovf) ovf_cnt++;
        if (rst) begin
            in_pulse = 0;
        end else if (lcd_e) begin
            if (!in_pulse) begin
                in_pulse  = 1;
                width     = 1;
                p_tx      = {lcd_rs, lcd_data};
                last_rise = edge_cnt;
                pulses++;
                prev_tx = last_tx;
                last_tx = p_tx;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got 0x%0h, expected no pulse", p_tx);
                end else begin
                    chk("bus_tx", int'(p_tx), int'(expq.pop_front()));
                end
                chk("lcd_rw", int'(lcd_rw), 0);
            end else begin
                width++;
                chk("bus_stable", int'({lcd_rs, lcd_data}), int'(p_tx));
            end
        end else if (in_pulse) begin
            in_pulse = 0;
            chk("pulse_width", width, int'(T_EN));
            chk("hold_data", int'({lcd_rs, lcd_data}), int'(p_tx));
        end
    end

    task automatic send(input logic wr, input logic clr, input logic [7:0] c, output int samp);
        @(negedge clk);
        i_wr = wr; i_clr = clr; i_char = c;
        @(negedge clk);
        i_wr = 1'b0; i_clr = 1'b0;
        samp = edge_cnt;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("idle_reached", int'(o_busy), 0);
    endtask

    task automatic wait_e(output int n);
        n = 0;
        while (!lcd_e && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("lcd_e_seen", int'(lcd_e), 1);
    endtask

    task automatic wr_char(input logic [7:0] c, output int n);
        int s;
        model_write(c);
        send(1'b1, 1'b0, c, s);
        wait_idle(n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s, p0, o0;
        rst = 1'b1; i_wr = 1'b0; i_clr = 1'b0; i_char = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_lcd_e", int'(lcd_e), 0);
        chk("rst_lcd_rs", int'(lcd_rs), 0);
        chk("rst_lcd_rw", int'(lcd_rw), 0);
        chk("rst_lcd_data", int'(lcd_data), 0);
        chk("rst_busy", int'(o_busy), 1);
        chk("rst_ovf", int'(o_ovf), 0);

        // Power-up init
        model_init();
        rst = 1'b0;
        wait_e(n);
        chk("first_pulse_edge", edge_cnt, 11);
        wait_idle(n);
        chk("init_done_edge", edge_cnt, 42);
        chk("init_pulses", pulses, 4);

        // Single write
        p0 = pulses;
        model_write(8'h35);
        send(1'b1, 1'b0, 8'h35, s);
        wait_idle(n);
        chk("wr_busy_cycles", n, 7);
        chk("wr_pulse_edge", last_rise, s + 1);
        chk("wr_pulses", pulses - p0, 1);
        chk("wr_tx", int'(last_tx), 9'h135);

        // Plain clear, then 33 writes across both lines and the wrap
        model_clear();
        send(1'b0, 1'b1, 8'h00, s);
        wait_idle(n);
        chk("clr_busy_cycles", n, 11);
        for (int i = 1; i <= 33; i++) begin
            wr_char(8'h31, n);
            if (i == 17) begin
                chk("line2_busy_cycles", n, 14);
                chk("line2_prefix", int'(prev_tx), 9'h0C0);
                chk("line2_char", int'(last_tx), 9'h131);
            end
            if (i == 33) begin
                chk("wrap_prefix", int'(prev_tx), 9'h080);
                chk("wrap_char", int'(last_tx), 9'h131);
            end
        end
        for (int i = 0; i < 31; i++) wr_char(8'h40 + 8'(i), n);

        // Clear beats a same-cycle write; wrap flag is dropped
        p0 = pulses; o0 = ovf_cnt;
        model_clear();
        send(1'b1, 1'b1, 8'h39, s);
        wait_idle(n);
        chk("clrpri_busy_cycles", n, 11);
        chk("clrpri_pulses", pulses - p0, 1);
        chk("clrpri_tx", int'(last_tx), 9'h001);
        chk("clrpri_ovf", ovf_cnt - o0, 0);
        wr_char(8'h41, n);
        chk("after_clr_busy", n, 7);
        chk("after_clr_tx", int'(last_tx), 9'h141);

        // Busy buffering and overflow
        p0 = pulses; o0 = ovf_cnt;
        model_write(8'h32);
        model_write(8'h33);
        send(1'b1, 1'b0, 8'h32, s);
        i_wr = 1'b1; i_char = 8'h33;
        @(negedge clk);
        i_char = 8'h34;
        @(negedge clk);
        i_wr = 1'b0;
        chk("ovf_pulse", int'(o_ovf), 1);
        @(negedge clk);
        chk("ovf_one_cycle", int'(o_ovf), 0);
        wait_idle(n);
        chk("buf_pulses", pulses - p0, 2);
        chk("buf_last_tx", int'(last_tx), 9'h133);
        chk("buf_ovf_count", ovf_cnt - o0, 1);

        // Pending clear discards a pending char; write behind a pending clear overflows
        p0 = pulses; o0 = ovf_cnt;
        model_write(8'h50);
        model_clear();
        send(1'b1, 1'b0, 8'h50, s);
        i_wr = 1'b1; i_char = 8'h51;
        @(negedge clk);
        i_wr = 1'b0; i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0; i_wr = 1'b1; i_char = 8'h52;
        @(negedge clk);
        i_wr = 1'b0;
        chk("pclr_ovf_pulse", int'(o_ovf), 1);
        wait_idle(n);
        chk("pclr_pulses", pulses - p0, 2);
        chk("pclr_last_tx", int'(last_tx), 9'h001);
        chk("pclr_ovf_count", ovf_cnt - o0, 1);

        // Reset in the middle of a pulse
        model_write(8'h36);
        send(1'b1, 1'b0, 8'h36, s);
        @(negedge clk);
        chk("pulse_before_rst", int'(lcd_e), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_e", int'(lcd_e), 0);
        chk("async_rst_busy", int'(o_busy), 1);
        chk("async_rst_data", int'(lcd_data), 0);
        chk("queue_before_rst", expq.size(), 0);
        expq.delete();
        p0 = pulses;
        model_init();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_e(n);
        chk("reinit_first_edge", edge_cnt, 11);
        wait_idle(n);
        chk("reinit_done_edge", edge_cnt, 42);
        chk("reinit_pulses", pulses - p0, 4);
        wr_char(8'h37, n);
        chk("post_rst_tx", int'(last_tx), 9'h137);

        repeat (3) @(negedge clk);
        chk("queue_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
